adsr_envelope: RTL and testbench

//   Applies an attack/decay/sustain/release amplitude envelope to the signed sample

---
 rtl/adsr_envelope.sv | 132 +++++++++++++
 tb/tb_adsr_envelope.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope applied to a signed ready/valid sample stream.
// The envelope advances one step per accepted sample; output is registered, latency 1.
module adsr_envelope #(
  parameter int unsigned width_p         = 24,
  parameter int unsigned env_width_p     = 16,
  parameter int unsigned attack_step_p   = 64,
  parameter int unsigned decay_step_p    = 16,
  parameter int unsigned sustain_level_p = 2**(env_width_p-1),
  parameter int unsigned release_step_p  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        gate_i,
  input  logic                        valid_i,
  input  logic signed [width_p-1:0]   data_i,
  output logic                        ready_o,
  output logic                        valid_o,
  output logic signed [width_p-1:0]   data_o,
  input  logic                        ready_i,
  output logic [env_width_p-1:0]      env_o,
  output logic                        busy_o
);

  localparam int unsigned prod_w = width_p + env_width_p + 1;
  localparam int unsigned ew1    = env_width_p + 1;

  localparam logic [env_width_p:0]   env_max_w = {1'b0, {env_width_p{1'b1}}};
  localparam logic [env_width_p:0]   attack_w  = ew1'(attack_step_p);
  localparam logic [env_width_p:0]   decay_w   = ew1'(decay_step_p);
  localparam logic [env_width_p:0]   release_w = ew1'(release_step_p);
  localparam logic [env_width_p-1:0] sustain_n = env_width_p'(sustain_level_p);
  localparam logic [env_width_p:0]   sustain_w = {1'b0, sustain_n};
  localparam logic [env_width_p-1:0] decay_n   = env_width_p'(decay_step_p);
  localparam logic [env_width_p-1:0] release_n = env_width_p'(release_step_p);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t                    state, state_next;
  logic [env_width_p-1:0]    env, env_next;
  logic [env_width_p:0]      env_w, up_w;
  logic                      accept;
  logic signed [prod_w-1:0]  sample_ext, env_ext, prod;
  logic signed [width_p-1:0] scaled;

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign env_o   = env;
  assign busy_o  = (state != IDLE);

  assign env_w = {1'b0, env};
  assign up_w  = env_w + attack_w;

  // Arithmetic shift of the full product floors toward -inf before truncation.
  assign sample_ext = prod_w'(data_i);
  assign env_ext    = prod_w'({1'b0, env});
  assign prod       = sample_ext * env_ext;
  assign scaled     = width_p'(prod >>> env_width_p);

  always_comb begin
    state_next = state;
    env_next   = env;
    if (accept) begin
      case (state)
        IDLE: begin
          env_next = '0;
          if (gate_i) state_next = ATTACK;
        end
        ATTACK: begin
          if (!gate_i) begin
            state_next = RELEASE;
          end else if (up_w >= env_max_w) begin
            env_next   = '1;
            state_next = DECAY;
          end else begin
            env_next = up_w[env_width_p-1:0];
          end
        end
        DECAY: begin
          // Distance-to-floor compare avoids wrapping when the step exceeds env.
          if (!gate_i) begin
            state_next = RELEASE;
          end else if (env_w <= sustain_w || (env_w - sustain_w) <= decay_w) begin
            env_next   = sustain_n;
            state_next = SUSTAIN;
          end else begin
            env_next = env - decay_n;
          end
        end
        SUSTAIN: begin
          if (!gate_i) state_next = RELEASE;
        end
        RELEASE: begin
          if (gate_i) begin
            state_next = ATTACK;
          end else if (env_w <= release_w) begin
            env_next   = '0;
            state_next = IDLE;
          end else begin
            env_next = env - release_n;
          end
        end
        default: begin
          state_next = IDLE;
          env_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      env   <= '0;
    end else begin
      state <= state_next;
      env   <= env_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= scaled;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: behavioural envelope model checked every cycle,
// plus literal expectations for the documented sequences.
module tb_adsr_envelope;

  localparam int W    = 24;
  localparam int EW   = 8;
  localparam int A    = 64;
  localparam int D    = 16;
  localparam int S    = 128;
  localparam int R    = 32;
  localparam int EMAX = 255;

  logic                clk     = 1'b0;
  logic                rst_i   = 1'b1;
  logic                gate_i  = 1'b0;
  logic                valid_i = 1'b0;
  logic signed [W-1:0] data_i  = '0;
  logic                ready_i = 1'b1;
  logic                ready_o, valid_o, busy_o;
  logic signed [W-1:0] data_o;
  logic [EW-1:0]       env_o;

  adsr_envelope #(
    .width_p(W), .env_width_p(EW), .attack_step_p(A),
    .decay_step_p(D), .sustain_level_p(S), .release_step_p(R)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .gate_i(gate_i), .valid_i(valid_i),
    .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .env_o(env_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: note phase, level, and the single output slot.
  typedef enum {M_IDLE, M_ATK, M_DEC, M_SUS, M_REL} mphase_t;
  mphase_t m_ph    = M_IDLE;
  int      m_env   = 0;
  bit      m_valid = 1'b0;
  longint  m_data  = 0;
  int      m_acc   = 0;
  int      dut_in  = 0;
  int      dut_out = 0;

  function automatic longint floor_scale(input longint x, input int e);
    longint p = x * e;
    longint q = 1 << EW;
    if (p >= 0) return p / q;
    return -((-p + q - 1) / q);
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_ph = M_IDLE; m_env = 0; m_valid = 1'b0; m_data = 0;
      m_acc = 0; dut_in = 0; dut_out = 0;
    end else begin
      if (valid_i && ready_o) dut_in++;
      if (valid_o && ready_i) dut_out++;
      if (valid_i && (!m_valid || ready_i)) begin
        m_data  = floor_scale(longint'(data_i), m_env);
        m_valid = 1'b1;
        m_acc++;
        case (m_ph)
          M_IDLE: if (gate_i) m_ph = M_ATK;
          M_ATK:
            if (!gate_i) m_ph = M_REL;
            else begin
              m_env = m_env + A;
              if (m_env >= EMAX) begin m_env = EMAX; m_ph = M_DEC; end
            end
          M_DEC:
            if (!gate_i) m_ph = M_REL;
            else begin
              m_env = m_env - D;
              if (m_env <= S) begin m_env = S; m_ph = M_SUS; end
            end
          M_SUS: if (!gate_i) m_ph = M_REL;
          M_REL:
            if (gate_i) m_ph = M_ATK;
            else begin
              m_env = m_env - R;
              if (m_env <= 0) begin m_env = 0; m_ph = M_IDLE; end
            end
          default: m_ph = M_IDLE;
        endcase
      end else if (ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst_i) begin
      chk("valid_o", longint'(valid_o), longint'(m_valid));
      chk("ready_o", longint'(ready_o), longint'(!m_valid || ready_i));
      chk("env_o",   longint'(env_o),   longint'(m_env));
      chk("busy_o",  longint'(busy_o),  longint'(m_ph != M_IDLE));
      if (m_valid) chk("data_o", longint'(data_o), m_data);
    end
  end

  // Called at negedge+1; one accepted beat, returns outputs one negedge later.
  task automatic beat(input bit g, input int d, output longint od, output int oe);
    gate_i  = g;
    data_i  = d[W-1:0];
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk); #1;
    od = longint'(data_o);
    oe = int'(env_o);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; gate_i = 1'b0; ready_i = 1'b1; data_i = '0;
    @(negedge clk); @(negedge clk);
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    longint od[16];
    int     oe[16];
    longint td;
    int     te;
    longint held;
    int     env_h;
    logic [31:0] r;
    int     exp_env[4];

    // Reset state
    rst_i = 1'b1;
    @(negedge clk); #1;
    chk("rst valid_o", longint'(valid_o), 0);
    chk("rst data_o",  longint'(data_o),  0);
    chk("rst env_o",   longint'(env_o),   0);
    chk("rst ready_o", longint'(ready_o), 1);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk_en = 1'b1;

    beat(1'b0, 1000, td, te);
    chk("idle data_o", td, 0);
    chk("idle busy_o", longint'(busy_o), 0);

    // Positive note through attack and decay into sustain
    for (int i = 0; i < 15; i++) beat(1'b1, 1000, od[i], oe[i]);
    chk("atk pos 0", od[1], 0);
    chk("atk pos 1", od[2], 250);
    chk("atk pos 2", od[3], 500);
    chk("atk pos 3", od[4], 750);
    chk("atk pos 4", od[5], 996);
    chk("dec first", od[6], 933);
    chk("sus env",   oe[12], 128);
    chk("sus data",  od[13], 500);

    // Negative samples floor toward -inf
    do_reset();
    for (int i = 0; i < 15; i++) beat(1'b1, -1000, od[i], oe[i]);
    chk("atk neg 0", od[1], 0);
    chk("atk neg 1", od[2], -250);
    chk("atk neg 2", od[3], -500);
    chk("atk neg 3", od[4], -750);
    chk("atk neg 4", od[5], -997);
    chk("sus neg",   od[13], -500);

    // Release to idle
    for (int i = 0; i < 5; i++) beat(1'b0, 1000, od[i], oe[i]);
    chk("rel env 0", oe[0], 128);
    chk("rel env 1", oe[1], 96);
    chk("rel env 2", oe[2], 64);
    chk("rel env 3", oe[3], 32);
    chk("rel env 4", oe[4], 0);
    chk("rel busy",  longint'(busy_o), 0);

    // Retrigger from env 64 during release
    for (int i = 0; i < 15; i++) beat(1'b1, 1000, td, te);
    for (int i = 0; i < 3; i++) beat(1'b0, 1000, td, te);
    chk("retrig pre env", te, 64);
    exp_env[0] = 64; exp_env[1] = 128; exp_env[2] = 192; exp_env[3] = 255;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1000, td, te);
      chk("retrig env", te, exp_env[i]);
    end
    chk("retrig busy", longint'(busy_o), 1);

    // Downstream stall holds output and freezes the envelope
    held  = longint'(data_o);
    env_h = int'(env_o);
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      data_i = r[W-1:0];
      gate_i = r[31];
      @(negedge clk); #1;
      chk("stall data_o",  longint'(data_o),  held);
      chk("stall ready_o", longint'(ready_o), 0);
      chk("stall env_o",   longint'(env_o),   env_h);
      chk("stall valid_o", longint'(valid_o), 1);
    end
    ready_i = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if (r[4:0] == 5'd0) gate_i = !gate_i;
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      r = $urandom;
      data_i = r[W-1:0];
      @(negedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("count in",  dut_in,  m_acc);
    chk("count out", dut_out, m_acc);

    // Asynchronous reset in the middle of decay
    do_reset();
    for (int i = 0; i < 7; i++) beat(1'b1, 1000, td, te);
    chk("pre-rst env", te, 223);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst valid_o", longint'(valid_o), 0);
    chk("arst data_o",  longint'(data_o),  0);
    chk("arst env_o",   longint'(env_o),   0);
    chk("arst busy_o",  longint'(busy_o),  0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    beat(1'b0, 1000, td, te);
    chk("post-rst data", td, 0);
    chk("post-rst busy", longint'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
